rr_dff_arbiter: RTL and testbench

Round-robin arbiter that shares one registered output stage (a single DW-wide pipeline flop) between NREQ valid/ready requesters. Each cycle the register can accept, the block picks one requesting source, loads its data and source index into the register, and presents them downstream with a valid/ready handshake. It sits wherever several producers feed one pipelined consumer. It guarantees one transfer per cycle under continuous load and starvation-free service.

---
 rtl/rr_dff_arbiter_if.sv | 24 ++
 rtl/rr_dff_arbiter.sv | 59 +++++
 tb/tb_rr_dff_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rr_dff_arbiter_if.sv
// rtl/rr_dff_arbiter_if.sv - requester/output handshake bundle for rr_dff_arbiter
interface rr_dff_arbiter_if #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/rr_dff_arbiter.sv
// rtl/rr_dff_arbiter.sv - round-robin arbiter feeding a single registered output stage
module rr_dff_arbiter #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic             clk,
  input logic             rst_n,
  rr_dff_arbiter_if.slave bus
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           any;
  logic           ld;
  logic           found;
  int             idx;

  assign any = |bus.req_valid;
  assign ld  = !bus.out_valid || bus.out_ready;

  // Search starts at ptr and wraps modulo NREQ, so non-power-of-2 counts never alias.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Gated by rst_n so no requester is accepted while the register is held in reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && ld && any)
      bus.req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
      ptr           <= '0;
    end else if (ld) begin
      if (any) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.req_data[int'(win)*DW +: DW];
        bus.out_id    <= win;
        ptr           <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_dff_arbiter.sv
// tb/tb_rr_dff_arbiter.sv - randomized and directed checks of rr_dff_arbiter against a behavioural model
module tb_rr_dff_arbiter;
  localparam int DW   = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_dff_arbiter_if #(.DW(DW), .NREQ(NREQ)) bus ();
  rr_dff_arbiter #(.DW(DW), .NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: output register contents and priority pointer
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_ptr;
  int            last_grant;
  int            waits [NREQ];
  logic [DW+IDW-1:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] rv, input int p);
    for (int k = 0; k < NREQ; k++)
      if (rv[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; last_grant = -1;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
    model_clear();
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive, compare against the model away from the edge, advance the model.
  task automatic cycle(input logic [NREQ-1:0] rv, input logic [NREQ*DW-1:0] rd, input logic ordy);
    logic          ld;
    int            w;
    logic [NREQ-1:0] exp_ready;
    logic [DW+IDW-1:0] head;
    bus.req_valid = rv; bus.req_data = rd; bus.out_ready = ordy;
    #1;
    ld = !m_valid || ordy;
    w  = pick(rv, m_ptr);
    exp_ready = '0;
    if (ld && w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(bus.out_data), 64'(m_data));
      chk("out_id", 64'(bus.out_id), 64'(m_id));
    end
    // in-order scoreboard from observed handshakes
    if (bus.out_valid && ordy) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL sb_underflow: got word %0h with nothing accepted", bus.out_data);
      end else begin
        head = sb.pop_front();
        chk("sb_word", 64'({bus.out_id, bus.out_data}), 64'(head));
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (rv[i] && bus.req_ready[i]) sb.push_back({IDW'(i), rd[i*DW +: DW]});
    last_grant = -1;
    if (ld) begin
      if (w >= 0) begin
        for (int i = 0; i < NREQ; i++)
          if (i != w) waits[i] = rv[i] ? waits[i] + 1 : 0;
        chk("fair_wait", 64'(waits[w]), 64'(waits[w] < NREQ ? waits[w] : NREQ - 1));
        waits[w] = 0;
        m_valid = 1'b1; m_data = rd[w*DW +: DW]; m_id = w; m_ptr = (w + 1) % NREQ;
        last_grant = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [NREQ*DW-1:0] rot_data;
  logic [NREQ-1:0]    pend;
  logic [NREQ*DW-1:0] pdata;
  logic [DW-1:0]      held_data;
  logic [IDW-1:0]     held_id;

  initial begin
    for (int i = 0; i < NREQ; i++) rot_data[i*DW +: DW] = DW'(32'hA0 + i);
    do_reset();

    // rotation with no bubbles
    for (int n = 0; n < 5; n++) begin
      cycle(4'b1111, rot_data, 1'b1);
      chk("rot_id", 64'(bus.out_id), 64'(n % 4));
      chk("rot_data", 64'(bus.out_data), 64'(32'hA0 + n % 4));
      chk("rot_valid", 64'(bus.out_valid), 64'(1));
    end

    // asynchronous reset while a word is held
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus.out_valid), 64'(0));
    chk("async_data", 64'(bus.out_data), 64'(0));
    chk("async_id", 64'(bus.out_id), 64'(0));
    do_reset();
    cycle(4'b1111, rot_data, 1'b1);
    chk("post_rst_id", 64'(bus.out_id), 64'(0));

    // sparse: grant 1 moves ptr to 2, then 0011 must wrap to 0, then 1
    do_reset();
    cycle(4'b0010, rot_data, 1'b1);
    chk("sparse_a", 64'(bus.out_id), 64'(1));
    cycle(4'b0011, rot_data, 1'b1);
    chk("sparse_b", 64'(bus.out_id), 64'(0));
    cycle(4'b0010, rot_data, 1'b1);
    chk("sparse_c", 64'(bus.out_id), 64'(1));

    // backpressure: word held stable, no acceptance, then id 2 loads on release
    cycle(4'b0001, rot_data, 1'b0);
    held_data = bus.out_data; held_id = bus.out_id;
    for (int n = 0; n < 5; n++) begin
      cycle(4'b0100, rot_data, 1'b0);
      chk("bp_ready", 64'(bus.req_ready), 64'(0));
      chk("bp_data", 64'(bus.out_data), 64'(held_data));
      chk("bp_id", 64'(bus.out_id), 64'(held_id));
    end
    cycle(4'b0100, rot_data, 1'b1);
    chk("bp_release_id", 64'(bus.out_id), 64'(2));
    chk("bp_release_data", 64'(bus.out_data), 64'(32'hA2));

    // drain to empty
    do_reset();
    rot_data[3*DW +: DW] = 32'hDEAD_BEEF;
    cycle(4'b1000, rot_data, 1'b1);
    chk("drain_valid1", 64'(bus.out_valid), 64'(1));
    chk("drain_id", 64'(bus.out_id), 64'(3));
    cycle(4'b0000, rot_data, 1'b1);
    chk("drain_valid0", 64'(bus.out_valid), 64'(0));
    chk("drain_data", 64'(bus.out_data), 64'(32'hDEAD_BEEF));

    // random traffic; requesters hold valid/data until accepted
    do_reset();
    pend = '0; pdata = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && ($urandom_range(0, 99) < 40)) begin
          pend[i] = 1'b1;
          pdata[i*DW +: DW] = $urandom;
        end
      cycle(pend, pdata, $urandom_range(0, 99) < 70);
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end
    for (int n = 0; n < 8; n++) cycle('0, pdata, 1'b1);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
